// File: rtl/ipif_req_arbiter_if.sv
// Bundles the requester-side and shared-slave-side IPIF signals of ipif_req_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface ipif_req_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]          Req_CS;
  logic [NUM_REQ-1:0]          Req_RNW;
  logic [NUM_REQ*ADDR_W-1:0]   Req_Addr;
  logic [NUM_REQ*DATA_W-1:0]   Req_Data;
  logic [NUM_REQ*DATA_W/8-1:0] Req_BE;
  logic [DATA_W-1:0]           Req_RdData;
  logic [NUM_REQ-1:0]          Req_RdAck;
  logic [NUM_REQ-1:0]          Req_WrAck;
  logic [NUM_REQ-1:0]          Req_Error;
  logic [NUM_REQ-1:0]          Grant;
  logic                        Bus2IP_CS;
  logic                        Bus2IP_RNW;
  logic [ADDR_W-1:0]           Bus2IP_Addr;
  logic [DATA_W-1:0]           Bus2IP_Data;
  logic [DATA_W/8-1:0]         Bus2IP_BE;
  logic [DATA_W-1:0]           IP2Bus_Data;
  logic                        IP2Bus_RdAck;
  logic                        IP2Bus_WrAck;
  logic                        IP2Bus_Error;
  logic [15:0]                 Timeout_Count;

  modport master (
    input  Req_CS, Req_RNW, Req_Addr, Req_Data, Req_BE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
    output Req_RdData, Req_RdAck, Req_WrAck, Req_Error, Grant,
    output Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE,
    output Timeout_Count
  );

  modport slave (
    output Req_CS, Req_RNW, Req_Addr, Req_Data, Req_BE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
    input  Req_RdData, Req_RdAck, Req_WrAck, Req_Error, Grant,
    input  Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE,
    input  Timeout_Count
  );
endinterface

// File: rtl/ipif_req_arbiter.sv
// Round-robin arbiter sharing one IPIF register slave between NUM_REQ requesters,
// with a data-phase timeout that forces an error completion.
module ipif_req_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REQ            = 2,
  parameter int C_TIMEOUT          = 64
) (
  input logic                Bus2IP_Clk,
  input logic                Bus2IP_Resetn,
  ipif_req_arbiter_if.master bus
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int BW = DW / 8;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] TMAX = (C_TIMEOUT > 0) ? 32'(C_TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state, state_n;
  logic [GW-1:0]      last_grant, last_grant_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic               cs, cs_n, rnw, rnw_n;
  logic [AW-1:0]      addr, addr_n;
  logic [DW-1:0]      wdata, wdata_n, rdata, rdata_n;
  logic [BW-1:0]      be, be_n;
  logic [NUM_REQ-1:0] rd_ack, rd_ack_n, wr_ack, wr_ack_n, err, err_n;
  logic [31:0]        timer, timer_n;
  logic [15:0]        tcount, tcount_n;
  logic               found;
  logic [GW-1:0]      win;
  int                 idx;

  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      cs         <= 1'b0;
      rnw        <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      be         <= '0;
      rdata      <= '0;
      rd_ack     <= '0;
      wr_ack     <= '0;
      err        <= '0;
      timer      <= '0;
      tcount     <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      cs         <= cs_n;
      rnw        <= rnw_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      be         <= be_n;
      rdata      <= rdata_n;
      rd_ack     <= rd_ack_n;
      wr_ack     <= wr_ack_n;
      err        <= err_n;
      timer      <= timer_n;
      tcount     <= tcount_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_n      = grant;
    cs_n         = cs;
    rnw_n        = rnw;
    addr_n       = addr;
    wdata_n      = wdata;
    be_n         = be;
    rdata_n      = rdata;
    rd_ack_n     = '0;
    wr_ack_n     = '0;
    err_n        = '0;
    timer_n      = timer;
    tcount_n     = tcount;
    found        = 1'b0;
    win          = last_grant;
    idx          = 0;

    // Scan starts just after the previous owner so a busy requester cannot starve others.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && bus.Req_CS[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          grant_n      = '0;
          grant_n[win] = 1'b1;
          cs_n         = 1'b1;
          rnw_n        = bus.Req_RNW[win];
          addr_n       = bus.Req_Addr[int'(win)*AW +: AW];
          wdata_n      = bus.Req_Data[int'(win)*DW +: DW];
          be_n         = bus.Req_BE[int'(win)*BW +: BW];
          last_grant_n = win;
          timer_n      = '0;
          state_n      = ACCESS;
        end
      end
      ACCESS: begin
        // A slave ack wins over a timer expiring in the same cycle.
        if (bus.IP2Bus_RdAck || bus.IP2Bus_WrAck) begin
          cs_n  = 1'b0;
          err_n = grant & {NUM_REQ{bus.IP2Bus_Error}};
          if (rnw) begin
            rd_ack_n = grant;
            rdata_n  = bus.IP2Bus_Data;
          end else begin
            wr_ack_n = grant;
          end
          state_n = DONE;
        end else if (C_TIMEOUT != 0 && timer == TMAX) begin
          cs_n  = 1'b0;
          err_n = grant;
          if (rnw) begin
            rd_ack_n = grant;
            rdata_n  = '0;
          end else begin
            wr_ack_n = grant;
          end
          tcount_n = sat_inc16(tcount);
          state_n  = DONE;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      DONE: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.Req_RdData    = rdata;
  assign bus.Req_RdAck     = rd_ack;
  assign bus.Req_WrAck     = wr_ack;
  assign bus.Req_Error     = err;
  assign bus.Grant         = grant;
  assign bus.Bus2IP_CS     = cs;
  assign bus.Bus2IP_RNW    = rnw;
  assign bus.Bus2IP_Addr   = addr;
  assign bus.Bus2IP_Data   = wdata;
  assign bus.Bus2IP_BE     = be;
  assign bus.Timeout_Count = tcount;
endmodule

// File: tb/tb_ipif_req_arbiter.sv
// Directed bench for ipif_req_arbiter: a cycle table for arbitration/acks, plus
// hand sequences for timeout, ack-at-expiry and mid-transaction reset.
module tb_ipif_req_arbiter;
  localparam logic [31:0] A0 = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h0000_0004;
  localparam logic [31:0] D0 = 32'hAAAA_0001;
  localparam logic [31:0] D1 = 32'h5555_0002;
  localparam logic [31:0] RD = 32'h2013_0415;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ipif_req_arbiter_if #(.DATA_W(32), .ADDR_W(32), .NUM_REQ(2)) bus ();

  ipif_req_arbiter #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .NUM_REQ(2),
    .C_TIMEOUT(64)
  ) dut (
    .Bus2IP_Clk(clk),
    .Bus2IP_Resetn(rstn),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  cs, rnw;
    logic        rd, wr, er;
    logic [31:0] ipd;
    logic        ecs;
    logic [1:0]  eg, erd, ewr, eer;
    logic [31:0] erdd;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic [1:0] cs, logic [1:0] rnw, logic rd, logic wr, logic er,
                              logic [31:0] ipd, logic ecs, logic [1:0] eg, logic [1:0] erd,
                              logic [1:0] ewr, logic [1:0] eer, logic [31:0] erdd);
    vec_t v;
    v.cs = cs; v.rnw = rnw; v.rd = rd; v.wr = wr; v.er = er; v.ipd = ipd;
    v.ecs = ecs; v.eg = eg; v.erd = erd; v.ewr = ewr; v.eer = eer; v.erdd = erdd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    bus.IP2Bus_RdAck = 1'b0;
    bus.IP2Bus_WrAck = 1'b0;
    bus.IP2Bus_Error = 1'b0;
    bus.IP2Bus_Data  = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    string tag;

    // Arbitration alternation, read, spurious ack and error write, cycle by cycle.
    vecs[0]  = mk(2'b11, 2'b00, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    vecs[1]  = mk(2'b11, 2'b00, 0, 1, 0, 0,  1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    vecs[2]  = mk(2'b11, 2'b00, 0, 0, 0, 0,  0, 2'b01, 2'b00, 2'b01, 2'b00, 0);
    vecs[3]  = mk(2'b11, 2'b00, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    vecs[4]  = mk(2'b11, 2'b00, 0, 1, 0, 0,  1, 2'b10, 2'b00, 2'b00, 2'b00, 0);
    vecs[5]  = mk(2'b11, 2'b00, 0, 0, 0, 0,  0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    vecs[6]  = mk(2'b11, 2'b00, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    vecs[7]  = mk(2'b11, 2'b00, 0, 1, 0, 0,  1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    vecs[8]  = mk(2'b11, 2'b00, 0, 0, 0, 0,  0, 2'b01, 2'b00, 2'b01, 2'b00, 0);
    vecs[9]  = mk(2'b11, 2'b00, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    vecs[10] = mk(2'b11, 2'b00, 0, 1, 0, 0,  1, 2'b10, 2'b00, 2'b00, 2'b00, 0);
    vecs[11] = mk(2'b00, 2'b00, 0, 0, 0, 0,  0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    vecs[12] = mk(2'b00, 2'b00, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    vecs[13] = mk(2'b01, 2'b01, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    vecs[14] = mk(2'b01, 2'b01, 0, 0, 0, 0,  1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    vecs[15] = mk(2'b01, 2'b01, 1, 0, 0, RD, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    vecs[16] = mk(2'b00, 2'b00, 0, 0, 0, 0,  0, 2'b01, 2'b01, 2'b00, 2'b00, RD);
    vecs[17] = mk(2'b00, 2'b00, 0, 1, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, RD);
    vecs[18] = mk(2'b01, 2'b00, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, RD);
    vecs[19] = mk(2'b01, 2'b00, 0, 1, 1, 0,  1, 2'b01, 2'b00, 2'b00, 2'b00, RD);
    vecs[20] = mk(2'b00, 2'b00, 0, 0, 0, 0,  0, 2'b01, 2'b00, 2'b01, 2'b01, RD);
    vecs[21] = mk(2'b00, 2'b00, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'b00, 2'b00, RD);

    rstn         = 1'b0;
    bus.Req_CS   = 2'b00;
    bus.Req_RNW  = 2'b00;
    bus.Req_Addr = {A1, A0};
    bus.Req_Data = {D1, D0};
    bus.Req_BE   = {4'h3, 4'hF};
    slave_idle();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      tag = $sformatf("v%0d", i);
      chk({tag, "_cs"},     32'(bus.Bus2IP_CS),  32'(vecs[i].ecs));
      chk({tag, "_grant"},  32'(bus.Grant),      32'(vecs[i].eg));
      chk({tag, "_rdack"},  32'(bus.Req_RdAck),  32'(vecs[i].erd));
      chk({tag, "_wrack"},  32'(bus.Req_WrAck),  32'(vecs[i].ewr));
      chk({tag, "_err"},    32'(bus.Req_Error),  32'(vecs[i].eer));
      chk({tag, "_rddata"}, bus.Req_RdData,      vecs[i].erdd);
      if (vecs[i].ecs) begin
        chk({tag, "_bdata"}, bus.Bus2IP_Data, (vecs[i].eg == 2'b01) ? D0 : D1);
        chk({tag, "_baddr"}, bus.Bus2IP_Addr, (vecs[i].eg == 2'b01) ? A0 : A1);
        chk({tag, "_bbe"},   32'(bus.Bus2IP_BE), (vecs[i].eg == 2'b01) ? 32'hF : 32'h3);
      end
      bus.Req_CS       = vecs[i].cs;
      bus.Req_RNW      = vecs[i].rnw;
      bus.IP2Bus_RdAck = vecs[i].rd;
      bus.IP2Bus_WrAck = vecs[i].wr;
      bus.IP2Bus_Error = vecs[i].er;
      bus.IP2Bus_Data  = vecs[i].ipd;
      tick();
    end
    chk("tcount_after_table", 32'(bus.Timeout_Count), 32'd0);

    // Slave never answers a req1 read: forced error completion after 64 CS cycles.
    bus.Req_CS  = 2'b10;
    bus.Req_RNW = 2'b10;
    slave_idle();
    tick();
    n = 0;
    while (bus.Bus2IP_CS && n < 200) begin
      n++;
      tick();
    end
    chk("to_cs_cycles",  32'(n),                 32'd64);
    chk("to_rdack",      32'(bus.Req_RdAck),     32'b10);
    chk("to_err",        32'(bus.Req_Error),     32'b10);
    chk("to_rddata",     bus.Req_RdData,         32'h0);
    chk("to_tcount",     32'(bus.Timeout_Count), 32'd1);
    bus.Req_CS = 2'b00;
    tick();
    chk("to_idle_grant", 32'(bus.Grant),         32'd0);

    // Ack lands in the very cycle the timer would expire: normal completion.
    bus.Req_CS  = 2'b01;
    bus.Req_RNW = 2'b01;
    tick();
    repeat (63) tick();
    chk("exp_cs_still_high", 32'(bus.Bus2IP_CS), 32'd1);
    bus.IP2Bus_RdAck = 1'b1;
    bus.IP2Bus_Data  = 32'hCAFE_F00D;
    tick();
    slave_idle();
    bus.Req_CS = 2'b00;
    chk("exp_rdack",  32'(bus.Req_RdAck),     32'b01);
    chk("exp_err",    32'(bus.Req_Error),     32'b00);
    chk("exp_rddata", bus.Req_RdData,         32'hCAFE_F00D);
    chk("exp_tcount", 32'(bus.Timeout_Count), 32'd1);
    tick();

    // Reset pulse while a req0 write is in ACCESS aborts it with no ack.
    bus.Req_CS  = 2'b01;
    bus.Req_RNW = 2'b00;
    tick();
    chk("rst_pre_cs", 32'(bus.Bus2IP_CS), 32'd1);
    rstn = 1'b0;
    tick();
    rstn       = 1'b1;
    bus.Req_CS = 2'b00;
    chk("rst_cs",     32'(bus.Bus2IP_CS),     32'd0);
    chk("rst_grant",  32'(bus.Grant),         32'd0);
    chk("rst_wrack",  32'(bus.Req_WrAck),     32'd0);
    chk("rst_tcount", 32'(bus.Timeout_Count), 32'd0);
    tick();
    chk("rst_noack",  32'(bus.Req_WrAck | bus.Req_RdAck), 32'd0);
    bus.Req_CS  = 2'b10;
    bus.Req_RNW = 2'b10;
    tick();
    chk("post_cs",    32'(bus.Bus2IP_CS),   32'd1);
    chk("post_grant", 32'(bus.Grant),       32'b10);
    chk("post_addr",  bus.Bus2IP_Addr,      A1);
    bus.IP2Bus_RdAck = 1'b1;
    bus.IP2Bus_Data  = 32'h1234_5678;
    tick();
    slave_idle();
    bus.Req_CS = 2'b00;
    chk("post_rdack",  32'(bus.Req_RdAck), 32'b10);
    chk("post_err",    32'(bus.Req_Error), 32'b00);
    chk("post_rddata", bus.Req_RdData,     32'h1234_5678);
    tick();
    chk("post_idle_grant", 32'(bus.Grant), 32'd0);
    chk("post_hold_rddata", bus.Req_RdData, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ipif_req_arbiter.md
Name: ipif_req_arbiter

Overview:
- Round-robin arbiter that shares one IPIF register slave between NUM_REQ IPIF-style requesters.
- Typical arrangement: requester 0 is the axi_lite_ipif_1bar output and requester 1 is a local management/self-test agent. The shared slave is an ipif_regs instance, e.g. the identifier date/time/id/tag bank.
- Serialises accesses, holds one grant per transaction, and guarantees completion through a data-phase timeout that returns an error ack.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width of all data buses.
- C_S_AXI_ADDR_WIDTH, 32: address width of all address buses.
- NUM_REQ, 2: number of requesters, range 2..8.
- C_TIMEOUT, 64: cycles in ACCESS before a forced error completion; 0 disables the timeout.

Ports:
- Bus2IP_Clk  in  1  single clock for all logic.
- Bus2IP_Resetn  in  1  reset, synchronous, active-low.
- Req_CS  in  NUM_REQ  per-requester chip select; held high until the requester sees its ack.
- Req_RNW  in  NUM_REQ  per-requester 1=read, 0=write.
- Req_Addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- Req_Data  in  NUM_REQ*DATA_W  packed write data.
- Req_BE  in  NUM_REQ*DATA_W/8  packed byte enables.
- Req_RdData  out  DATA_W  shared read data, valid only with a RdAck.
- Req_RdAck  out  NUM_REQ  one-cycle read-complete pulse.
- Req_WrAck  out  NUM_REQ  one-cycle write-complete pulse.
- Req_Error  out  NUM_REQ  error flag, valid only with an ack.
- Grant  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- Bus2IP_CS  out  1  slave chip select.
- Bus2IP_RNW  out  1  slave direction.
- Bus2IP_Addr  out  ADDR_W  slave address.
- Bus2IP_Data  out  DATA_W  slave write data.
- Bus2IP_BE  out  DATA_W/8  slave byte enables.
- IP2Bus_Data  in  DATA_W  slave read data.
- IP2Bus_RdAck  in  1  slave read ack.
- IP2Bus_WrAck  in  1  slave write ack.
- IP2Bus_Error  in  1  slave error.
- Timeout_Count  out  16  saturating count of timeouts.

Behaviour:
- Clock and reset: one clock, Bus2IP_Clk. Reset Bus2IP_Resetn is synchronous and active-low.
- Reset values:
  - All outputs are 0 and state is IDLE.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - Timeout_Count = 0.
  - Reset mid-transaction aborts it silently: no ack is issued, and Bus2IP_CS is low in the first cycle after reset.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any Req_CS is high, the winner is the first requester with Req_CS high, scanning from last_grant+1 modulo NUM_REQ.
  - On the winning cycle, register the winner's RNW/Addr/Data/BE onto the Bus2IP_* outputs, set Grant, set Bus2IP_CS, update last_grant, clear the timer, and go to ACCESS.
  - Bus2IP_CS therefore rises in the cycle after the request is sampled.
- ACCESS:
  - Bus2IP_* outputs are held stable.
  - On (IP2Bus_RdAck | IP2Bus_WrAck):
    - Drop Bus2IP_CS.
    - Pulse the matching Req_RdAck[g]/Req_WrAck[g] in the next cycle, with Req_Error[g] = IP2Bus_Error.
    - On a read, register Req_RdData = IP2Bus_Data.
    - Go to DONE.
  - Otherwise the timer increments. If C_TIMEOUT != 0 and the timer reaches C_TIMEOUT-1:
    - Drop CS.
    - Pulse the ack chosen by the latched RNW, with Req_Error[g] = 1 and Req_RdData = 0.
    - Increment Timeout_Count, saturating at 16'hFFFF.
    - Go to DONE.
- DONE:
  - Lasts exactly one cycle; the ack pulse and Grant are visible.
  - Then clear Grant and go to IDLE.
  - Req_CS is not sampled in DONE. A requester still asserting CS in the following IDLE cycle is treated as a new request.
- Latency:
  - Request sampled in cycle 0; Bus2IP_CS is high in cycle 1.
  - A slave ack in cycle k gives a requester ack in cycle k+1.
  - Minimum turnaround between grants is 1 idle cycle, plus DONE.
- Boundary conditions:
  - IP2Bus acks arriving in IDLE or DONE are ignored.
  - Simultaneous RdAck and WrAck: the ack follows the latched RNW.
  - A requester that drops Req_CS during ACCESS does not abort the bus transaction; the ack is still pulsed and the requester ignores it.
  - An ack arriving in the same cycle the timer expires counts as a normal completion; no timeout is recorded.
  - Round-robin wraps from NUM_REQ-1 to 0.
  - A continuously requesting winner cannot starve others: with all requesters active, grants follow the order 0,1,...,NUM_REQ-1,0.
  - Req_RdData holds its last value between reads.

Test Plan:
1. After reset: req0 reads addr 0x0 while the slave returns 0x20130415 with RdAck one cycle after CS → Bus2IP_CS high cycle 1, Req_RdAck[0] pulses cycle 3 with Req_RdData = 0x20130415 and Req_Error = 0; Grant = 01 during cycles 1-3.
2. Req0 and req1 both write continuously after reset → grants alternate 0,1,0,1; Bus2IP_Data matches the owner's data; each owner gets exactly one WrAck per transaction.
3. Slave never acks, C_TIMEOUT = 64, req1 read → CS high for 64 cycles, then Req_RdAck[1] = 1, Req_Error[1] = 1, Req_RdData = 0, Timeout_Count = 1.
4. Slave acks in the same cycle the timer expires → normal ack with data; Timeout_Count unchanged. Spurious IP2Bus_WrAck in IDLE → no Req ack.
5. Bus2IP_Resetn low for one cycle while in ACCESS → next cycle Bus2IP_CS = 0, Grant = 0, no ack; a subsequent request from req1 alone is served normally.
6. IP2Bus_Error = 1 with WrAck on a req0 write → Req_WrAck[0] = 1, Req_Error[0] = 1; Timeout_Count unchanged.
